// File: rtl/rggen_external_bus_arbiter.sv
// Round-robin arbiter sharing one external register-bus slave among N requesters.
// Registers the winning request downstream and routes the response to the owner.
module rggen_external_bus_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int STROBE_WIDTH   = BUS_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [N_MASTERS-1:0]               i_valid,
  input  logic [2*N_MASTERS-1:0]             i_access,
  input  logic [ADDRESS_WIDTH*N_MASTERS-1:0] i_address,
  input  logic [BUS_WIDTH*N_MASTERS-1:0]     i_write_data,
  input  logic [STROBE_WIDTH*N_MASTERS-1:0]  i_strobe,
  output logic [N_MASTERS-1:0]               o_ready,
  output logic [1:0]                         o_status,
  output logic [BUS_WIDTH-1:0]               o_read_data,
  output logic [N_MASTERS-1:0]               o_grant,
  output logic                               o_bus_valid,
  output logic [1:0]                         o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]           o_bus_address,
  output logic [BUS_WIDTH-1:0]               o_bus_write_data,
  output logic [STROBE_WIDTH-1:0]            o_bus_strobe,
  input  logic                               i_bus_ready,
  input  logic [1:0]                         i_bus_status,
  input  logic [BUS_WIDTH-1:0]               i_bus_read_data
);
  localparam logic [1:0] RGGEN_READ        = 2'b10;
  localparam logic [1:0] RGGEN_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;
  localparam int IW = $clog2(N_MASTERS);
  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] owner;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic          found;
  logic [CW-1:0] count;
  logic          timeout;
  logic          done;

  // first valid requester after the previous owner, wrapping around
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = IW'((int'(last) + i) % N_MASTERS);
      if (!found && i_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    assign timeout = (state == BUSY) && !i_bus_ready &&
                     (count == CW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end

  assign done = (state == BUSY) && (i_bus_ready || timeout);

  always_comb begin
    o_ready     = '0;
    o_status    = RGGEN_OKAY;
    o_read_data = '0;
    if (done) begin
      o_ready = o_grant;
      if (i_bus_ready) begin
        o_status    = i_bus_status;
        o_read_data = i_bus_read_data;
      end else begin
        o_status = RGGEN_SLAVE_ERROR;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      last             <= IW'(N_MASTERS - 1);
      owner            <= '0;
      count            <= '0;
      o_grant          <= '0;
      o_bus_valid      <= 1'b0;
      o_bus_access     <= RGGEN_READ;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|i_valid) begin
            state            <= BUSY;
            owner            <= winner;
            count            <= '0;
            o_grant          <= N_MASTERS'(1) << winner;
            o_bus_valid      <= 1'b1;
            o_bus_access     <= i_access[2*int'(winner)+:2];
            o_bus_address    <=
              i_address[ADDRESS_WIDTH*int'(winner)+:ADDRESS_WIDTH];
            o_bus_write_data <=
              i_write_data[BUS_WIDTH*int'(winner)+:BUS_WIDTH];
            o_bus_strobe     <=
              i_strobe[STROBE_WIDTH*int'(winner)+:STROBE_WIDTH];
          end
        end
        BUSY: begin
          if (done) begin
            state       <= IDLE;
            last        <= owner;
            o_grant     <= '0;
            o_bus_valid <= 1'b0;
          end else if (count != '1) begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rggen_external_bus_arbiter.sv
// Bench for rggen_external_bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_rggen_external_bus_arbiter;
  localparam int NM = 3;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = 4;
  localparam int TO = 4;
  localparam logic [1:0] RD     = 2'b10;
  localparam logic [1:0] WR     = 2'b11;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NM-1:0]    valid;
  logic [2*NM-1:0]  access;
  logic [AW*NM-1:0] address;
  logic [BW*NM-1:0] write_data;
  logic [SW*NM-1:0] strobe;
  logic [NM-1:0]    ready;
  logic [1:0]       status;
  logic [BW-1:0]    read_data;
  logic [NM-1:0]    grant;
  logic             bus_valid;
  logic [1:0]       bus_access;
  logic [AW-1:0]    bus_address;
  logic [BW-1:0]    bus_write_data;
  logic [SW-1:0]    bus_strobe;
  logic             bus_ready;
  logic [1:0]       bus_status;
  logic [BW-1:0]    bus_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  bit            m_busy;
  int            m_owner;
  int            m_last;
  int            m_wait;
  logic [1:0]    m_acc;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_wd;
  logic [SW-1:0] m_strb;

  bit            e_done;
  logic [NM-1:0] e_ready;
  logic [NM-1:0] e_grant;
  logic [1:0]    e_status;
  logic [BW-1:0] e_rdata;

  rggen_external_bus_arbiter #(
    .N_MASTERS(NM), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW),
    .STROBE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid), .i_access(access), .i_address(address),
    .i_write_data(write_data), .i_strobe(strobe),
    .o_ready(ready), .o_status(status), .o_read_data(read_data),
    .o_grant(grant), .o_bus_valid(bus_valid),
    .o_bus_access(bus_access), .o_bus_address(bus_address),
    .o_bus_write_data(bus_write_data), .o_bus_strobe(bus_strobe),
    .i_bus_ready(bus_ready), .i_bus_status(bus_status),
    .i_bus_read_data(bus_read_data)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = NM - 1;
    m_wait = 0;
  endtask

  task automatic model_expect();
    e_done   = m_busy && (bus_ready || m_wait == TO - 1);
    e_grant  = m_busy ? NM'(1 << m_owner) : '0;
    e_ready  = e_done ? e_grant : '0;
    e_status = !e_done ? OKAY : (bus_ready ? bus_status : SLVERR);
    e_rdata  = (e_done && bus_ready) ? bus_read_data : '0;
  endtask

  // advance one cycle: model follows the inputs seen at the rising edge
  task automatic tick();
    model_expect();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      if (e_done) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else begin
        m_wait++;
      end
    end else if (|valid) begin
      for (int k = 1; k <= NM; k++) begin
        int idx;
        idx = (m_last + k) % NM;
        if (!m_busy && valid[idx]) begin
          m_busy  = 1'b1;
          m_owner = idx;
          m_wait  = 0;
          m_acc   = access[2*idx+:2];
          m_addr  = address[AW*idx+:AW];
          m_wd    = write_data[BW*idx+:BW];
          m_strb  = strobe[SW*idx+:SW];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid         = '0;
    access        = '0;
    address       = '0;
    write_data    = '0;
    strobe        = '0;
    bus_ready     = 1'b0;
    bus_status    = OKAY;
    bus_read_data = '0;
  endtask

  task automatic set_req(input int k, input logic [1:0] acc,
                         input logic [AW-1:0] a, input logic [BW-1:0] d,
                         input logic [SW-1:0] s);
    access[2*k+:2]      = acc;
    address[AW*k+:AW]   = a;
    write_data[BW*k+:BW] = d;
    strobe[SW*k+:SW]    = s;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus_valid, bus_access, bus_address, bus_write_data, bus_strobe}
        !== {1'b0, RD, 8'h00, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_bus got v=%b acc=%b a=%h d=%h s=%h",
               bus_valid, bus_access, bus_address, bus_write_data, bus_strobe);
    end
    n_tests++;
    if ({grant, ready, status, read_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_resp got g=%b r=%b st=%b rd=%h expected all 0",
               grant, ready, status, read_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    idle_inputs();
    valid = 3'b010;
    set_req(1, RD, 8'h10, '0, '0);
    tick();
    #1;
    n_tests++;
    if ({bus_valid, grant, bus_access, bus_address, ready}
        !== {1'b1, 3'b010, RD, 8'h10, 3'b000}) begin
      n_fail++;
      $display("FAIL read_issue got v=%b g=%b acc=%b a=%h r=%b",
               bus_valid, grant, bus_access, bus_address, ready);
    end
    tick();
    #1;
    n_tests++;
    if (ready !== 3'b000) begin
      n_fail++;
      $display("FAIL read_wait got ready=%b expected 000", ready);
    end
    tick();
    bus_ready     = 1'b1;
    bus_read_data = 32'hCAFE0001;
    #1;
    n_tests++;
    if ({ready, status, read_data} !== {3'b010, OKAY, 32'hCAFE0001}) begin
      n_fail++;
      $display("FAIL read_done got r=%b st=%b rd=%h expected 010/00/cafe0001",
               ready, status, read_data);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if ({bus_valid, grant, ready} !== '0) begin
      n_fail++;
      $display("FAIL read_release got v=%b g=%b r=%b expected 0",
               bus_valid, grant, ready);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [NM-1:0] eg [8];
    eg = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
    idle_inputs();
    valid = 3'b011;
    set_req(0, RD, 8'h01, '0, '0);
    set_req(1, RD, 8'h02, '0, '0);
    bus_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) valid = '0;
      #1;
      n_tests++;
      if ({bus_valid, grant, ready} !== {|eg[i], eg[i], eg[i]}) begin
        n_fail++;
        $display("FAIL simul_c%0d got v=%b g=%b r=%b expected g=%b",
                 i, bus_valid, grant, ready, eg[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_payload();
    idle_inputs();
    valid = 3'b001;
    set_req(0, WR, 8'h5A, 32'h12345678, 4'b0101);
    tick();
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_tests++;
      if ({grant, bus_access, bus_write_data, bus_strobe, ready}
          !== {3'b001, WR, 32'h12345678, 4'b0101, 3'b000}) begin
        n_fail++;
        $display("FAIL write_hold_c%0d got g=%b acc=%b d=%h s=%b r=%b",
                 c, grant, bus_access, bus_write_data, bus_strobe, ready);
      end
      tick();
    end
    bus_ready = 1'b1;
    #1;
    n_tests++;
    if ({ready, status, bus_write_data} !== {3'b001, OKAY, 32'h12345678}) begin
      n_fail++;
      $display("FAIL write_done_c4 got r=%b st=%b d=%h expected 001/00",
               ready, status, bus_write_data);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_release got v=%b expected 0", bus_valid);
    end
    tick();
  endtask

  task automatic test_timeout();
    idle_inputs();
    valid = 3'b100;
    set_req(2, RD, 8'h33, '0, '0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_tests++;
      if ({ready, bus_valid, grant} !== {3'b000, 1'b1, 3'b100}) begin
        n_fail++;
        $display("FAIL timeout_wait_c%0d got r=%b v=%b g=%b",
                 c, ready, bus_valid, grant);
      end
      tick();
    end
    bus_read_data = 32'hDEADBEEF;
    valid = '0;
    #1;
    n_tests++;
    if ({ready, status, read_data} !== {3'b100, SLVERR, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_fire got r=%b st=%b rd=%h expected 100/10/0",
               ready, status, read_data);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if ({bus_valid, grant, ready} !== '0) begin
      n_fail++;
      $display("FAIL timeout_release got v=%b g=%b r=%b expected 0",
               bus_valid, grant, ready);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    valid = 3'b010;
    set_req(1, RD, 8'h44, '0, '0);
    tick();
    bus_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus_valid, grant, ready, status, read_data, bus_address} !== '0) begin
      n_fail++;
      $display("FAIL midreset got v=%b g=%b r=%b st=%b rd=%h a=%h",
               bus_valid, grant, ready, status, read_data, bus_address);
    end
    model_reset();
    tick();
    rst_n = 1'b1;
    bus_ready = 1'b0;
    valid = 3'b011;
    set_req(0, RD, 8'h01, '0, '0);
    tick();
    #1;
    n_tests++;
    if ({bus_valid, grant, bus_address} !== {1'b1, 3'b001, 8'h01}) begin
      n_fail++;
      $display("FAIL midreset_first got v=%b g=%b a=%h expected 1/001/01",
               bus_valid, grant, bus_address);
    end
    bus_ready = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      valid         = NM'($urandom_range(0, 7));
      access        = 6'($urandom);
      address       = 24'($urandom);
      write_data    = {$urandom, $urandom, $urandom};
      strobe        = 12'($urandom);
      bus_ready     = ($urandom_range(0, 9) < 4);
      bus_status    = 2'($urandom);
      bus_read_data = $urandom;
      #1;
      model_expect();
      n_tests++;
      if ({ready, status, read_data, grant, bus_valid}
          !== {e_ready, e_status, e_rdata, e_grant, m_busy}) begin
        n_fail++;
        $display("FAIL rand_resp_c%0d got r=%b st=%b rd=%h g=%b v=%b exp r=%b st=%b rd=%h g=%b v=%b",
                 cyc, ready, status, read_data, grant, bus_valid,
                 e_ready, e_status, e_rdata, e_grant, m_busy);
      end
      if (m_busy) begin
        n_tests++;
        if ({bus_access, bus_address, bus_write_data, bus_strobe}
            !== {m_acc, m_addr, m_wd, m_strb}) begin
          n_fail++;
          $display("FAIL rand_bus_c%0d got acc=%b a=%h d=%h s=%h exp acc=%b a=%h d=%h s=%h",
                   cyc, bus_access, bus_address, bus_write_data, bus_strobe,
                   m_acc, m_addr, m_wd, m_strb);
        end
      end
      tick();
    end
    idle_inputs();
    bus_ready = 1'b1;
    repeat (3) tick();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_write_payload();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rggen_external_bus_arbiter.md
# rggen_external_bus_arbiter

Round-robin arbiter that shares one external register-bus slave port among N requesters, each typically the bus side of an external-register block. It latches the winning request into a registered downstream request, holds it until the slave completes the transfer, and routes the response back to the granted requester. An optional timeout completes stalled transfers with an error.

## Interface
- N_MASTERS, 2: number of requesters, 2 to 16.
- ADDRESS_WIDTH, 8: address width.
- BUS_WIDTH, 32: data width.
- STROBE_WIDTH, BUS_WIDTH/8: byte-strobe width.
- TIMEOUT_CYCLES, 0: stall limit in cycles; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  N_MASTERS  per-requester request valid
- i_access  in  2*N_MASTERS  per-requester rggen_access, packed, requester k at [2k+:2]
- i_address  in  ADDRESS_WIDTH*N_MASTERS  per-requester address, packed
- i_write_data  in  BUS_WIDTH*N_MASTERS  per-requester write data, packed
- i_strobe  in  STROBE_WIDTH*N_MASTERS  per-requester strobe, packed
- o_ready  out  N_MASTERS  per-requester completion pulse
- o_status  out  2  response status, broadcast, qualified by o_ready
- o_read_data  out  BUS_WIDTH  read data, broadcast, qualified by o_ready
- o_grant  out  N_MASTERS  one-hot id of the current owner; 0 when idle
- o_bus_valid  out  1  downstream request valid
- o_bus_access  out  2  downstream access
- o_bus_address  out  ADDRESS_WIDTH  downstream address
- o_bus_write_data  out  BUS_WIDTH  downstream write data
- o_bus_strobe  out  STROBE_WIDTH  downstream strobe
- i_bus_ready  in  1  downstream completion
- i_bus_status  in  2  downstream status
- i_bus_read_data  in  BUS_WIDTH  downstream read data

## Operation
- The FSM has two states, IDLE and BUSY. Reset enters IDLE.
- **IDLE, any i_valid set**
  - Select a winner by round-robin. Search starts at (last+1) mod N_MASTERS and wraps.
  - Register the winner's access, address, write_data and strobe onto the o_bus_* outputs.
  - Set o_grant to the winner's one-hot value, set o_bus_valid, and go to BUSY.
- **BUSY**
  - o_bus_* are held stable.
  - On i_bus_ready:
    - Combinationally, o_ready[grant]=1, o_status=i_bus_status, o_read_data=i_bus_read_data.
    - Next cycle: o_bus_valid=0, o_grant=0, last=grant, state IDLE.
- Outside a completion, o_status=RGGEN_OKAY, o_read_data=0, and o_ready=0.
- **Timeout (TIMEOUT_CYCLES>0)**
  - The counter is cleared on entering BUSY and increments every BUSY cycle without i_bus_ready. It is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates.
  - In the cycle where counter==TIMEOUT_CYCLES-1 and i_bus_ready=0:
    - o_ready[grant]=1, o_status=RGGEN_SLAVE_ERROR, o_read_data=0.
    - The FSM then leaves BUSY exactly as on a normal completion.
  - i_bus_ready in the timeout cycle takes priority, giving a normal completion.
- Requesters must hold i_valid and their payload until o_ready. If a granted requester drops i_valid, it is ignored: the latched transfer still completes and o_ready is still pulsed.
- Non-granted requesters wait without limit. Round-robin bounds each requester's wait to N_MASTERS-1 transfers.
- Reset values:
  - o_bus_valid=0, o_bus_access=RGGEN_READ, o_bus_address=0, o_bus_write_data=0, o_bus_strobe=0.
  - o_grant=0, o_ready=0, o_status=RGGEN_OKAY, o_read_data=0.
  - last=N_MASTERS-1, so requester 0 has first priority.
- Reset mid-transfer abandons the transfer immediately. No o_ready is issued.

## Timing
- Request sampled at cycle 0 → o_bus_valid at cycle 1.
- Earliest o_ready is cycle 1, if i_bus_ready=1 in cycle 1.
- One mandatory IDLE cycle follows each completion. Peak throughput is one transfer per 2 cycles.
- o_ready is a single-cycle pulse per transfer. At most one bit of o_ready is set in any cycle.
- Combinational paths are limited to i_bus_ready/status/read_data → o_ready/o_status/o_read_data. All o_bus_* outputs and o_grant are registered.

## Test plan
- **Single read:** after reset, requester 1 issues RGGEN_READ at address 0x10; slave readies 2 cycles after o_bus_valid with read_data 0xCAFE0001 and status OKAY → o_bus_address=0x10, o_ready=2'b10 for 1 cycle, o_read_data=0xCAFE0001.
- **Simultaneous requests:** both requesters hold i_valid, slave always ready → grants alternate 0,1,0,1, with o_bus_valid high every other cycle.
- **Write payload:** requester 0 issues RGGEN_WRITE with data 0x12345678 and strobe 4'b0101 → o_bus_write_data and o_bus_strobe match exactly and stay stable until i_bus_ready.
- **Timeout:** TIMEOUT_CYCLES=4 and the slave never readies → o_ready pulses in the 4th BUSY cycle with status RGGEN_SLAVE_ERROR and read_data 0; o_bus_valid=0 the next cycle. Repeat with i_bus_ready arriving in the 4th cycle → status OKAY.
- **Reset mid-transfer:** assert i_rst_n low while BUSY → all outputs return to reset values asynchronously and no o_ready is issued. After release, requester 0 wins first.
